// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - Trivium widths, tap positions, FSM encoding and single-round function.
package trivium_pkg;

    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;
    localparam int STATE_W = 288;

    // Vector index = Trivium bit number minus one (state[0] is s1).
    localparam int A_LAST  = 92;   // s93, last bit of register A
    localparam int B_LAST  = 176;  // s177, last bit of register B

    localparam int T1_A    = 65;
    localparam int T1_B    = 92;
    localparam int T1_AND0 = 90;
    localparam int T1_AND1 = 91;
    localparam int T1_X    = 170;

    localparam int T2_A    = 161;
    localparam int T2_B    = 176;
    localparam int T2_AND0 = 174;
    localparam int T2_AND1 = 175;
    localparam int T2_X    = 263;

    localparam int T3_A    = 242;
    localparam int T3_B    = 287;
    localparam int T3_AND0 = 285;
    localparam int T3_AND1 = 286;
    localparam int T3_X    = 68;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_READY  = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic               z;
    } round_t;

    function automatic round_t trivium_round(input logic [STATE_W-1:0] s);
        round_t r;
        logic   t1;
        logic   t2;
        logic   t3;
        t1 = s[T1_A] ^ s[T1_B];
        t2 = s[T2_A] ^ s[T2_B];
        t3 = s[T3_A] ^ s[T3_B];
        r.z = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[T1_AND0] & s[T1_AND1]) ^ s[T1_X];
        t2 = t2 ^ (s[T2_AND0] & s[T2_AND1]) ^ s[T2_X];
        t3 = t3 ^ (s[T3_AND0] & s[T3_AND1]) ^ s[T3_X];
        r.state = {s[STATE_W-2:B_LAST+1], t2,
                   s[B_LAST-1:A_LAST+1], t1,
                   s[A_LAST-1:0],        t3};
        return r;
    endfunction

endpackage

// File: rtl/trivium_round8.sv
// rtl/trivium_round8.sv - Eight chained Trivium rounds in one combinational step.
module trivium_round8
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic [7:0]         z_out
);

    logic [STATE_W-1:0] acc;
    round_t             rnd;

    // z_out[0] is the first round's keystream bit.
    always_comb begin
        acc   = state_in;
        rnd   = '0;
        z_out = '0;
        for (int i = 0; i < 8; i++) begin
            rnd      = trivium_round(acc);
            acc      = rnd.state;
            z_out[i] = rnd.z;
        end
        state_out = acc;
    end

endmodule

// File: rtl/trivium_core.sv
// rtl/trivium_core.sv - Rekeyable Trivium keystream generator, one byte per clock.
module trivium_core
    import trivium_pkg::*;
#(
    parameter int INIT_ROUNDS = 1152
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    input  logic             start,
    output logic             busy,
    output logic [7:0]       keystream_byte,
    output logic             keystream_valid,
    input  logic             keystream_read
);

    localparam int WARM_STEPS = INIT_ROUNDS / 8;
    localparam int CNT_W      = $clog2(WARM_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARM_STEPS);

    fsm_e               fsm_q;
    fsm_e               fsm_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] adv_state;
    logic [STATE_W-1:0] load_state;
    logic [7:0]         z8;

    trivium_round8 u_round8 (
        .state_in  (state_q),
        .state_out (adv_state),
        .z_out     (z8)
    );

    // s288..s286 = 1, s285..s178 = 0, s177..s174 = 0, IV, s93..s81 = 0, key.
    assign load_state = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    fsm_d   = ST_WARMUP;
                    cnt_d   = CNT_INIT;
                    state_d = load_state;
                end
            end
            ST_WARMUP: begin
                state_d = adv_state;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d = ST_READY;
                end
            end
            ST_READY: begin
                // A rekey takes priority and drops any simultaneous read.
                if (start) begin
                    fsm_d   = ST_WARMUP;
                    cnt_d   = CNT_INIT;
                    state_d = load_state;
                end else if (keystream_read) begin
                    state_d = adv_state;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy            = (fsm_q == ST_WARMUP);
        keystream_valid = (fsm_q == ST_READY);
        keystream_byte  = keystream_valid ? z8 : 8'h00;
    end

endmodule

// File: tb/tb_trivium_core.sv
// tb/tb_trivium_core.sv - Randomized bench for trivium_core against a bit-serial Trivium model.
module tb_trivium_core;

    localparam int N_DEF = 144;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key;
    logic [79:0] iv;
    logic        start;
    logic        rd;
    logic        busy;
    logic        valid;
    logic [7:0]  kbyte;

    logic [79:0] key8;
    logic [79:0] iv8;
    logic        start8;
    logic        rd8;
    logic        busy8;
    logic        valid8;
    logic [7:0]  kbyte8;

    int checks   = 0;
    int failures = 0;

    bit         ms [1:288];
    logic [7:0] got_q [$];
    int         unstable;
    int         notvalid;

    always #5 clk = ~clk;

    trivium_core dut (
        .clk             (clk),
        .rst             (rst),
        .key             (key),
        .iv              (iv),
        .start           (start),
        .busy            (busy),
        .keystream_byte  (kbyte),
        .keystream_valid (valid),
        .keystream_read  (rd)
    );

    trivium_core #(.INIT_ROUNDS(8)) dut8 (
        .clk             (clk),
        .rst             (rst),
        .key             (key8),
        .iv              (iv8),
        .start           (start8),
        .busy            (busy8),
        .keystream_byte  (kbyte8),
        .keystream_valid (valid8),
        .keystream_read  (rd8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    // Reference: textbook bit-serial Trivium on a 1-indexed bit array.
    task automatic model_round(output bit z);
        bit t1;
        bit t2;
        bit t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic model_load(input logic [79:0] k, input logic [79:0] v, input int rounds);
        bit z;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ms[i+1]  = k[i];
            ms[i+94] = v[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        repeat (rounds) model_round(z);
    endtask

    task automatic model_byte(output logic [7:0] b);
        bit z;
        for (int i = 0; i < 8; i++) begin
            model_round(z);
            b[i] = z;
        end
    endtask

    task automatic do_start(input logic [79:0] k, input logic [79:0] v);
        key   = k;
        iv    = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts post-edge samples with busy high; bounded so a stuck DUT cannot hang the run.
    task automatic count_busy(output int cnt, output int overlap);
        cnt     = 0;
        overlap = 0;
        while (busy && cnt < 400) begin
            if (valid) overlap++;
            cnt++;
            tick();
        end
    endtask

    // gap = unread cycles between reads; each held byte must not move.
    task automatic read_bytes(input int n, input int gap);
        logic [7:0] b;
        got_q.delete();
        unstable = 0;
        notvalid = 0;
        for (int i = 0; i < n; i++) begin
            b = kbyte;
            if (!valid) notvalid++;
            for (int g = 0; g < gap; g++) begin
                rd = 1'b0;
                tick();
                if (kbyte !== b || !valid) unstable++;
            end
            rd = 1'b1;
            tick();
            got_q.push_back(b);
        end
        rd = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; rd = 0; key = '0; iv = '0;
        start8 = 0; rd8 = 0; key8 = '0; iv8 = '0;
        tick(); tick();
        checks++;
        if ({busy, valid, kbyte} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b valid=%0b byte=%02h expected all 0", busy, valid, kbyte);
        end
        checks++;
        if ({busy8, valid8, kbyte8} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs8: got busy=%0b valid=%0b byte=%02h expected all 0", busy8, valid8, kbyte8);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%0b valid=%0b expected 0 0", busy, valid);
        end
    endtask

    task automatic test_zero_key;
        int         cnt;
        int         ov;
        logic [7:0] e;
        do_start('0, '0);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy_rise: got busy=%0b valid=%0b expected 1 0", busy, valid);
        end
        count_busy(cnt, ov);
        checks++;
        if (cnt !== N_DEF) begin
            failures++;
            $display("FAIL zero_busy_len: got %0d expected %0d", cnt, N_DEF);
        end
        checks++;
        if (ov !== 0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_valid_rise: got overlap=%0d valid=%0b expected 0 1", ov, valid);
        end
        read_bytes(64, 0);
        model_load('0, '0, 1152);
        checks++;
        if (notvalid !== 0) begin
            failures++;
            $display("FAIL zero_b2b_valid: got %0d invalid reads expected 0", notvalid);
        end
        for (int i = 0; i < 64; i++) begin
            model_byte(e);
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL zero_byte[%0d]: got %02h expected %02h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_short_init;
        logic [7:0] e;
        key8   = 80'h80;
        iv8    = '0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || valid8 !== 1'b0) begin
            failures++;
            $display("FAIL short_busy: got busy=%0b valid=%0b expected 1 0", busy8, valid8);
        end
        tick();
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b1) begin
            failures++;
            $display("FAIL short_valid: got busy=%0b valid=%0b expected 0 1", busy8, valid8);
        end
        model_load(80'h80, '0, 8);
        rd8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            model_byte(e);
            checks++;
            if (kbyte8 !== e || valid8 !== 1'b1) begin
                failures++;
                $display("FAIL short_byte[%0d]: got %02h valid=%0b expected %02h", i, kbyte8, valid8, e);
            end
            tick();
        end
        rd8 = 1'b0;
    endtask

    task automatic test_throttle;
        int         cnt;
        int         ov;
        logic [7:0] e;
        do_start('0, '0);
        rd = 1'b1;
        count_busy(cnt, ov);
        rd = 1'b0;
        checks++;
        if (cnt !== N_DEF || valid !== 1'b1) begin
            failures++;
            $display("FAIL read_in_warmup: got busy_len=%0d valid=%0b expected %0d 1", cnt, valid, N_DEF);
        end
        read_bytes(20, 2);
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL throttle_stable: got %0d changes expected 0", unstable);
        end
        model_load('0, '0, 1152);
        for (int i = 0; i < 20; i++) begin
            model_byte(e);
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL throttle_byte[%0d]: got %02h expected %02h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_start_in_warmup;
        int          cnt;
        int          ov;
        logic [79:0] k1;
        logic [79:0] v1;
        logic [7:0]  e;
        k1 = rand80();
        v1 = rand80();
        do_start(k1, v1);
        repeat (49) tick();
        do_start(rand80(), rand80());
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL warm_start_busy: got %0b expected 1", busy);
        end
        count_busy(cnt, ov);
        checks++;
        if (cnt !== N_DEF - 50 || valid !== 1'b1) begin
            failures++;
            $display("FAIL warm_start_timing: got %0d valid=%0b expected %0d 1", cnt, valid, N_DEF - 50);
        end
        read_bytes(8, 0);
        model_load(k1, v1, 1152);
        for (int i = 0; i < 8; i++) begin
            model_byte(e);
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL warm_start_byte[%0d]: got %02h expected %02h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_rekey_ready;
        int          cnt;
        int          ov;
        logic [79:0] k;
        logic [79:0] v;
        logic [7:0]  e;
        k = rand80();
        v = rand80();
        do_start(k, v);
        count_busy(cnt, ov);
        checks++;
        if (cnt !== N_DEF || ov !== 0) begin
            failures++;
            $display("FAIL rekey_busy: got %0d overlap=%0d expected %0d 0", cnt, ov, N_DEF);
        end
        read_bytes(16, $urandom_range(0, 1));
        model_load(k, v, 1152);
        for (int i = 0; i < 16; i++) begin
            model_byte(e);
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL rekey_byte[%0d]: got %02h expected %02h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_start_with_read;
        int          cnt;
        int          ov;
        logic [79:0] k;
        logic [79:0] v;
        logic [7:0]  e;
        read_bytes(3, 0);
        k     = rand80();
        v     = rand80();
        rd    = 1'b1;
        do_start(k, v);
        rd    = 1'b0;
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL start_read_load: got busy=%0b valid=%0b expected 1 0", busy, valid);
        end
        count_busy(cnt, ov);
        checks++;
        if (cnt !== N_DEF) begin
            failures++;
            $display("FAIL start_read_busy: got %0d expected %0d", cnt, N_DEF);
        end
        read_bytes(8, 0);
        model_load(k, v, 1152);
        for (int i = 0; i < 8; i++) begin
            model_byte(e);
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL start_read_byte[%0d]: got %02h expected %02h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_async_rst;
        int          cnt;
        int          ov;
        logic [79:0] k;
        logic [79:0] v;
        logic [7:0]  e;
        do_start(rand80(), rand80());
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, kbyte} !== 10'b0) begin
            failures++;
            $display("FAIL rst_warmup: got busy=%0b valid=%0b byte=%02h expected all 0", busy, valid, kbyte);
        end
        #1 rst = 1'b0;
        repeat (200) tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_resume: got busy=%0b valid=%0b expected 0 0", busy, valid);
        end
        do_start(rand80(), rand80());
        count_busy(cnt, ov);
        read_bytes(2, 0);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, kbyte} !== 10'b0) begin
            failures++;
            $display("FAIL rst_ready: got busy=%0b valid=%0b byte=%02h expected all 0", busy, valid, kbyte);
        end
        rst = 1'b0;
        tick();
        k = rand80();
        v = rand80();
        do_start(k, v);
        count_busy(cnt, ov);
        checks++;
        if (cnt !== N_DEF || valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart: got busy_len=%0d valid=%0b expected %0d 1", cnt, valid, N_DEF);
        end
        read_bytes(16, 0);
        model_load(k, v, 1152);
        for (int i = 0; i < 16; i++) begin
            model_byte(e);
            checks++;
            if (got_q[i] !== e) begin
                failures++;
                $display("FAIL rst_restart_byte[%0d]: got %02h expected %02h", i, got_q[i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_short_init();
        test_throttle();
        test_start_in_warmup();
        test_rekey_ready();
        test_start_with_read();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
